// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle for axi_lite_master.
// master modport drives AW/W/AR and the B/R readies.
interface axi_lite_master_if #(
  parameter int C_ADDR_WIDTH = 9,
  parameter int C_DATA_WIDTH = 32
);
  logic [C_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [C_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator: cmd port in, rsp port out.
// Optional watchdog abort: define AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master #(
  parameter int         C_ADDR_WIDTH     = 9,
  parameter int         C_DATA_WIDTH     = 32,
  parameter logic [2:0] C_PROT           = 3'b000,
  parameter int         C_TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  axi_lite_master_if.master         axi
);

  if (C_DATA_WIDTH != 32 && C_DATA_WIDTH != 64) begin : g_bad_dw
    $error("axi_lite_master: C_DATA_WIDTH must be 32 or 64");
  end
  if (C_TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("axi_lite_master: C_TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_t;

  state_t state;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic aw_wait;
  logic w_wait;

  assign aw_hs   = axi.awvalid && axi.awready;
  assign w_hs    = axi.wvalid && axi.wready;
  assign b_hs    = axi.bvalid && axi.bready;
  assign ar_hs   = axi.arvalid && axi.arready;
  assign r_hs    = axi.rvalid && axi.rready;
  assign aw_wait = axi.awvalid && !axi.awready;
  assign w_wait  = axi.wvalid && !axi.wready;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(C_TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            busy;
  logic            hs_any;
  logic            wd_hit;

  assign busy = (state == S_WR) ||
                (state == S_WR_RESP) ||
                (state == S_RD_ADDR) ||
                (state == S_RD_DATA);
  assign hs_any = aw_hs || w_hs || b_hs ||
                  ar_hs || r_hs;
  assign wd_hit = busy &&
    (wd_cnt == WD_W'(C_TIMEOUT_CYCLES - 1));

  // Every handshake is progress, so it restarts the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (!busy || hs_any || wd_hit) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      axi.awaddr  <= '0;
      axi.awprot  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.araddr  <= '0;
      axi.arprot  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
    end else begin
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
      if (wd_hit) begin
        axi.awvalid <= 1'b0;
        axi.wvalid  <= 1'b0;
        axi.bready  <= 1'b0;
        axi.arvalid <= 1'b0;
        axi.rready  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_resp    <= 2'b10;
        rsp_rdata   <= '0;
        rsp_timeout <= 1'b1;
        state       <= S_RSP;
      end else
`endif
      begin
        unique case (state)
          S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
              cmd_ready <= 1'b0;
              if (cmd_write) begin
                axi.awaddr  <= cmd_addr;
                axi.awprot  <= C_PROT;
                axi.wdata   <= cmd_wdata;
                axi.wstrb   <= cmd_wstrb;
                axi.awvalid <= 1'b1;
                axi.wvalid  <= 1'b1;
                state       <= S_WR;
              end else begin
                axi.araddr  <= cmd_addr;
                axi.arprot  <= C_PROT;
                axi.arvalid <= 1'b1;
                state       <= S_RD_ADDR;
              end
            end else begin
              cmd_ready <= 1'b1;
            end
          end
          // AW and W retire independently; B opens once both are gone.
          S_WR: begin
            if (aw_hs) axi.awvalid <= 1'b0;
            if (w_hs)  axi.wvalid  <= 1'b0;
            if (!aw_wait && !w_wait) begin
              axi.bready <= 1'b1;
              state      <= S_WR_RESP;
            end
          end
          S_WR_RESP: begin
            if (b_hs) begin
              rsp_resp   <= axi.bresp;
              rsp_rdata  <= '0;
              axi.bready <= 1'b0;
              rsp_valid  <= 1'b1;
              state      <= S_RSP;
            end
          end
          S_RD_ADDR: begin
            if (ar_hs) begin
              axi.arvalid <= 1'b0;
              axi.rready  <= 1'b1;
              state       <= S_RD_DATA;
            end
          end
          S_RD_DATA: begin
            if (r_hs) begin
              rsp_rdata  <= axi.rdata;
              rsp_resp   <= axi.rresp;
              axi.rready <= 1'b0;
              rsp_valid  <= 1'b1;
              state      <= S_RSP;
            end
          end
          S_RSP: begin
            if (rsp_ready) begin
              rsp_valid   <= 1'b0;
              cmd_ready   <= 1'b1;
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
              rsp_timeout <= 1'b0;
`endif
              state       <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master against a small register-file slave.
// Slave readiness is registered, with per-channel extra wait knobs.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  axi_lite_master_if #(
    .C_ADDR_WIDTH(9),
    .C_DATA_WIDTH(32)
  ) bus ();

  axi_lite_master #(
    .C_ADDR_WIDTH    (9),
    .C_DATA_WIDTH    (32),
    .C_PROT          (3'b000),
    .C_TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .axi        (bus)
  );

  always #5 clk = ~clk;

  bit   aw_tie;
  bit   w_tie;
  bit   ar_tie;
  int   aw_dly;
  int   w_dly;
  int   ar_dly;
  logic [1:0] b_resp_k;
  logic [1:0] r_resp_k;

  logic [31:0] mem [0:127];
  logic aw_rdy_r, w_rdy_r, ar_rdy_r;
  int   aw_cnt, w_cnt, ar_cnt;
  logic aw_got, w_got;
  logic [8:0]  aw_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;
  logic        bvalid_r, rvalid_r;
  logic [31:0] rdata_r;
  logic        s_aw_hs, s_w_hs;
  logic [8:0]  wa;
  logic [31:0] wd;
  logic [3:0]  ws;

  assign bus.awready = aw_tie | aw_rdy_r;
  assign bus.wready  = w_tie | w_rdy_r;
  assign bus.arready = ar_tie | ar_rdy_r;
  assign bus.bvalid  = bvalid_r;
  assign bus.bresp   = b_resp_k;
  assign bus.rvalid  = rvalid_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = r_resp_k;
  assign s_aw_hs = bus.awvalid & bus.awready;
  assign s_w_hs  = bus.wvalid & bus.wready;
  assign wa = s_aw_hs ? bus.awaddr : aw_a;
  assign wd = s_w_hs ? bus.wdata : w_d;
  assign ws = s_w_hs ? bus.wstrb : w_s;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_rdy_r <= 0; w_rdy_r <= 0; ar_rdy_r <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 0; w_got <= 0;
      aw_a <= '0; w_d <= '0; w_s <= '0;
      bvalid_r <= 0; rvalid_r <= 0; rdata_r <= '0;
    end else begin
      if (bus.awvalid && !bus.awready) begin
        if (aw_cnt >= aw_dly) aw_rdy_r <= 1;
        else aw_cnt <= aw_cnt + 1;
      end else begin
        aw_rdy_r <= 0; aw_cnt <= 0;
      end
      if (bus.wvalid && !bus.wready) begin
        if (w_cnt >= w_dly) w_rdy_r <= 1;
        else w_cnt <= w_cnt + 1;
      end else begin
        w_rdy_r <= 0; w_cnt <= 0;
      end
      if (bus.arvalid && !bus.arready) begin
        if (ar_cnt >= ar_dly) ar_rdy_r <= 1;
        else ar_cnt <= ar_cnt + 1;
      end else begin
        ar_rdy_r <= 0; ar_cnt <= 0;
      end
      if (bus.bvalid && bus.bready) bvalid_r <= 0;
      if (s_aw_hs) begin
        aw_got <= 1; aw_a <= bus.awaddr;
      end
      if (s_w_hs) begin
        w_got <= 1; w_d <= bus.wdata; w_s <= bus.wstrb;
      end
      if ((aw_got | s_aw_hs) && (w_got | s_w_hs)) begin
        for (int i = 0; i < 4; i++)
          if (ws[i]) mem[wa[8:2]][8*i +: 8] <= wd[8*i +: 8];
        bvalid_r <= 1; aw_got <= 0; w_got <= 0;
      end
      if (bus.rvalid && bus.rready) rvalid_r <= 0;
      if (bus.arvalid && bus.arready) begin
        rvalid_r <= 1;
        rdata_r  <= mem[bus.araddr[8:2]];
      end
    end
  end

  int cyc = 0;
  int n_awv = 0, n_wv = 0, n_awhs = 0, n_whs = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.awvalid) n_awv <= n_awv + 1;
    if (bus.wvalid) n_wv <= n_wv + 1;
    if (s_aw_hs) n_awhs <= n_awhs + 1;
    if (s_w_hs) n_whs <= n_whs + 1;
  end

  int n_chk = 0;
  int n_pass = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic send(input bit wr, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    cmd_valid = 1;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    chk("accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 0;
    acc_cyc = cyc;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic [1:0] r, output int lat);
    for (int i = 0; i < 200 && !rsp_valid; i++) @(negedge clk);
    chk("rsp_arrive", rsp_valid, 1);
    lat = cyc - acc_cyc;
    d = rsp_rdata; r = rsp_resp;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  int lat, s_awv, s_wv, s_awhs, s_whs, cnt;

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1;
    aw_tie = 0; w_tie = 0; ar_tie = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    b_resp_k = 2'b00; r_resp_k = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    rst = 1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);

    send(1, 9'h010, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("wr_awvalid", bus.awvalid, 1);
    chk("wr_wvalid", bus.wvalid, 1);
    chk("wr_awaddr", bus.awaddr, 9'h010);
    chk("wr_wdata", bus.wdata, 32'hDEADBEEF);
    chk("wr_cmd_ready", cmd_ready, 0);
    get_rsp(d, r, lat);
    chk("wr_lat", lat, 3);
    chk("wr_resp", r, 0);
    chk("wr_rdata", d, 0);

    send(0, 9'h010, 32'h0, 4'h0);
    @(negedge clk);
    chk("rd_arvalid", bus.arvalid, 1);
    chk("rd_araddr", bus.araddr, 9'h010);
    get_rsp(d, r, lat);
    chk("rd_lat", lat, 3);
    chk("rd_rdata", d, 32'hDEADBEEF);
    chk("rd_resp", r, 0);

    aw_tie = 1; w_dly = 4;
    s_awv = n_awv; s_wv = n_wv; s_awhs = n_awhs; s_whs = n_whs;
    send(1, 9'h030, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    get_rsp(d, r, lat);
    chk("wslow_lat", lat, 7);
    chk("wslow_resp", r, 0);
    chk("wslow_awv_cyc", n_awv - s_awv, 1);
    chk("wslow_wv_cyc", n_wv - s_wv, 6);
    chk("wslow_aw_hs", n_awhs - s_awhs, 1);
    chk("wslow_w_hs", n_whs - s_whs, 1);
    aw_tie = 0; w_dly = 0;
    send(0, 9'h030, 32'h0, 4'h0);
    @(negedge clk);
    get_rsp(d, r, lat);
    chk("wslow_readback", d, 32'hCAFEF00D);

    send(1, 9'h020, 32'h12345678, 4'hF);
    @(negedge clk);
    get_rsp(d, r, lat);
    send(1, 9'h020, 32'h000000AA, 4'b0001);
    @(negedge clk);
    get_rsp(d, r, lat);
    send(0, 9'h020, 32'h0, 4'h0);
    @(negedge clk);
    get_rsp(d, r, lat);
    chk("strb_readback", d, 32'h123456AA);

    b_resp_k = 2'b10;
    send(1, 9'h044, 32'h1, 4'hF);
    @(negedge clk);
    get_rsp(d, r, lat);
    chk("bresp_slverr", r, 2'b10);
    b_resp_k = 2'b00; r_resp_k = 2'b11;
    send(0, 9'h010, 32'h0, 4'h0);
    @(negedge clk);
    get_rsp(d, r, lat);
    chk("rresp_decerr", r, 2'b11);
    chk("rresp_rdata", d, 32'hDEADBEEF);
    r_resp_k = 2'b00;

    rsp_ready = 0;
    send(0, 9'h010, 32'h0, 4'h0);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    cmd_write = 1; cmd_addr = 9'h040;
    cmd_wdata = 32'h55; cmd_wstrb = 4'hF; cmd_valid = 1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("hold_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_rsp_valid", rsp_valid, 0);
    chk("b2b_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 0;
    acc_cyc = cyc;
    @(negedge clk);
    chk("b2b_awvalid", bus.awvalid, 1);
    chk("b2b_cmd_ready_lo", cmd_ready, 0);
    get_rsp(d, r, lat);
    chk("b2b_lat", lat, 3);

    ar_dly = 100000;
    send(0, 9'h050, 32'h0, 4'h0);
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.arvalid) break;
      cnt++;
    end
    chk("to_arvalid_cyc", cnt, 16);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_resp", rsp_resp, 2'b10);
    chk("to_flag", rsp_timeout, 1);
    chk("to_rdata", rsp_rdata, 0);
    @(posedge clk);
    @(negedge clk);
    chk("to_flag_clr", rsp_timeout, 0);
    send(0, 9'h060, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
`else
    repeat (100) @(negedge clk);
    chk("nto_arvalid", bus.arvalid, 1);
    chk("nto_rsp_valid", rsp_valid, 0);
    chk("nto_flag", rsp_timeout, 0);
`endif
    #2 rst = 0;
    #1;
    chk("midrst_arvalid", bus.arvalid, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    ar_dly = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("recover_ready", cmd_ready, 1);
    send(0, 9'h010, 32'h0, 4'h0);
    @(negedge clk);
    get_rsp(d, r, lat);
    chk("recover_rdata", d, 32'hDEADBEEF);
    chk("recover_lat", lat, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
AXI4-Lite initiator that turns single-beat commands from a simple valid/ready command port into AXI4-Lite read or write transactions, and returns the result on a valid/ready response port. It is the counterpart to the team's AXI4-Lite register-file slaves. Typical uses are driving those slaves from a local controller, a debug bridge or a testbench-free self-check. Only one transaction is outstanding at a time.

Parameters:
C_ADDR_WIDTH, 9, AXI address width in bits
C_DATA_WIDTH, 32, AXI data width in bits; legal values are 32 and 64
C_PROT, 3'b000, constant value driven on awprot and arprot
C_TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles; used only when AXI_LITE_MASTER_TIMEOUT_EN is defined

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block accepts command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  C_ADDR_WIDTH  byte address
cmd_wdata  in  C_DATA_WIDTH  write data
cmd_wstrb  in  C_DATA_WIDTH/8  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  C_DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  captured BRESP or RRESP
rsp_timeout  out  1  transaction aborted by watchdog; constant 0 without the macro
awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite master-side directions and widths

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0, including cmd_ready, all valid/ready outputs, addr/data/strb outputs, rsp_rdata, rsp_resp and rsp_timeout.
  - FSM goes to IDLE and the watchdog counter clears.
- States: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP. All outputs are registered.
- IDLE:
  - cmd_ready is driven 1; its first high cycle is the first clk edge after reset release.
  - On cmd_valid && cmd_ready: capture the command and drive cmd_ready 0.
  - Write command: drive awvalid=1, wvalid=1 and load awaddr/wdata/wstrb from the command, all visible the next cycle. Go to WR.
  - Read command: drive arvalid=1 and araddr, visible the next cycle. Go to RD_ADDR.
- WR:
  - awvalid drops on awvalid && awready; wvalid drops on wvalid && wready. Each is tracked independently and the two may complete in either order or in the same cycle.
  - When both handshakes are done, drive bready=1 and go to WR_RESP. Neither valid is ever re-asserted for the same command.
- WR_RESP: on bvalid && bready, capture bresp into rsp_resp, set rsp_rdata=0, drive bready 0 and rsp_valid 1, go to RSP.
- RD_ADDR: on arvalid && arready, drive arvalid 0 and rready 1, go to RD_DATA.
- RD_DATA: on rvalid && rready, capture rdata into rsp_rdata and rresp into rsp_resp, drive rready 0 and rsp_valid 1, go to RSP.
- RSP:
  - rsp_valid and the response fields hold stable until rsp_ready.
  - On rsp_valid && rsp_ready: drive rsp_valid 0 and cmd_ready 1, go to IDLE.
  - A command offered while in RSP is not accepted.
- Valid/ready rule: a valid output never depends combinationally on the matching ready input. Address and data outputs stay stable while their valid is high.
- Minimum turnaround, with a zero-wait slave and rsp_ready tied high:
  - write: cmd accept to rsp_valid = 3 cycles;
  - read: cmd accept to rsp_valid = 3 cycles.
- Back-to-back commands: the next cmd is accepted 1 cycle after the response handshake.
- bresp/rresp values of SLVERR and DECERR are passed through unchanged; the block never retries.
- Reset mid-transaction: all valids drop immediately and the transaction is abandoned. The slave is assumed to be reset by the same rst.

Optional Feature:
AXI_LITE_MASTER_TIMEOUT_EN:
- Defined:
  - A counter runs while the FSM is in WR, WR_RESP, RD_ADDR or RD_DATA. It clears on every state change and on every individual handshake.
  - When the counter reaches C_TIMEOUT_CYCLES-1, all AXI valid/ready outputs drop and the FSM goes to RSP with rsp_resp=2'b10, rsp_rdata=0 and rsp_timeout=1.
  - rsp_timeout clears on the response handshake.
  - Known limitation: a late B or R from the slave is not consumed and may be accepted by the next transaction of the same type.
- Undefined: no counter is built, rsp_timeout is tied to 0, and the block waits indefinitely.

Test Plan:
- Write 0xDEADBEEF, wstrb 4'hF, addr 0x010 to a zero-wait slave -> awvalid and wvalid rise together 1 cycle after accept; rsp_valid 3 cycles after accept with rsp_resp=0 and rsp_rdata=0.
- Read addr 0x010 after the write above -> araddr=0x010; rsp_rdata=0xDEADBEEF, rsp_resp=0.
- Slave holds wready low 5 cycles while awready=1 -> awvalid drops after 1 cycle, wvalid is held 6 cycles; exactly one AW and one W handshake; correct response returned.
- Write 0x000000AA with wstrb 4'b0001 to addr 0x020, which holds 0x12345678 -> a following read returns 0x123456AA.
- rsp_ready held low 10 cycles with cmd_valid high -> rsp_valid and fields are stable; cmd_ready stays 0; the next cmd is accepted 1 cycle after rsp_ready rises.
- With the macro defined and C_TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops after 16 cycles; rsp_resp=2'b10, rsp_timeout=1. Without the macro -> arvalid is still high after 100 cycles.
